// File: rtl/ram_fifo_pkg.sv
// ram_fifo_pkg: shared definitions for the RAM-backed FIFO controller.
//   state_t    - controller FSM encoding (IDLE, RD_WAIT)
//   fifo_depth - number of RAM words addressed by an address of a given width
package ram_fifo_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_t;

  function automatic int unsigned fifo_depth(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

endpackage

// File: rtl/ram_fifo_ptr.sv
// ram_fifo_ptr: ADDR_WIDTH-bit wrapping pointer, used for the FIFO write and
// read positions in RAM.
// Ports:
//   clk - rising-edge clock
//   rst - asynchronous active-low reset (pointer clears to 0)
//   inc - advance the pointer by one at the next edge
//   ptr - current pointer value; wraps from DEPTH-1 to 0
module ram_fifo_ptr #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inc,
  output logic [ADDR_WIDTH-1:0] ptr
);

  logic [ADDR_WIDTH-1:0] ptr_r;

  // Pointer register; overflow of the natural binary width gives the wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_r <= {ADDR_WIDTH{1'b0}};
    end else if (inc) begin
      ptr_r <= ptr_r + ADDR_WIDTH'(1'b1);
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign ptr = ptr_r;

endmodule

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: FIFO controller in front of a single-port synchronous-read
// RAM. Converts a valid/ready write stream and a valid/ready read stream into
// RAM we/din/addr, prefetching one word into an output register.
// Read prefetches own the RAM port ahead of writes, but a prefetch can only
// start when the output register is empty, so writes always get the port
// while a word is waiting for the consumer.
// Ports:
//   clk, rst           - clock, asynchronous active-low reset
//   wr_valid/wr_ready  - write handshake, wr_data is the word
//   rd_valid/rd_ready  - read handshake, rd_data is the output register
//   ram_we/ram_din/ram_addr - RAM control, ram_dout is RAM read data (1-cycle)
//   level              - words held (RAM count plus output register)
//   almost_full        - only with RAM_FIFO_CTRL_AFULL_EN defined; registered,
//                        high when level >= AF_THRESH
// Optional feature macro: RAM_FIFO_CTRL_AFULL_EN
module ram_fifo_ctrl
  import ram_fifo_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 10
`ifdef RAM_FIFO_CTRL_AFULL_EN
  ,
  parameter int AF_THRESH  = 2**ADDR_WIDTH - 2
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [WIDTH-1:0]      wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  ram_we,
  output logic [WIDTH-1:0]      ram_din,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [WIDTH-1:0]      ram_dout,
  output logic [ADDR_WIDTH:0]   level
`ifdef RAM_FIFO_CTRL_AFULL_EN
  ,
  output logic                  almost_full
`endif
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(fifo_depth(ADDR_WIDTH));
  localparam logic [ADDR_WIDTH:0] ZERO_C  = {(ADDR_WIDTH+1){1'b0}};
  localparam logic [ADDR_WIDTH:0] ONE_C   = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                state_r;
  logic                  rd_valid_r;
  logic [WIDTH-1:0]      rd_data_r;
  logic [ADDR_WIDTH:0]   count_r;
  logic [ADDR_WIDTH:0]   level_r;

  logic                  issue_rd_s;
  logic                  wr_ready_s;
  logic                  wr_fire_s;
  logic                  consume_s;
  logic                  rd_valid_next_s;
  logic [ADDR_WIDTH:0]   count_next_s;
  logic [ADDR_WIDTH:0]   level_next_s;
  logic [ADDR_WIDTH-1:0] wr_ptr_s;
  logic [ADDR_WIDTH-1:0] rd_ptr_s;
  logic [ADDR_WIDTH-1:0] ram_addr_s;

  // Port arbitration and handshake qualification.
  always_comb begin
    issue_rd_s = (state_r == IDLE) && !rd_valid_r && (count_r != ZERO_C);
    wr_ready_s = (state_r == IDLE) && !issue_rd_s && (count_r != DEPTH_C);
    wr_fire_s  = wr_valid && wr_ready_s;
    consume_s  = rd_valid_r && rd_ready;
  end

  // RAM address select. rd_ptr has already advanced by the RD_WAIT cycle, so
  // the issued address is rebuilt as rd_ptr-1 to keep it steady on the port.
  always_comb begin
    ram_addr_s = wr_ptr_s;
    if (state_r == RD_WAIT) begin
      ram_addr_s = rd_ptr_s - ADDR_WIDTH'(1'b1);
    end else if (issue_rd_s) begin
      ram_addr_s = rd_ptr_s;
    end else begin
      ram_addr_s = wr_ptr_s;
    end
  end

  // Next-state occupancy. Write accept and read issue never coincide because
  // wr_ready is low during issue_rd.
  always_comb begin
    count_next_s    = count_r;
    rd_valid_next_s = rd_valid_r;
    if (wr_fire_s) begin
      count_next_s = count_r + ONE_C;
    end else if (issue_rd_s) begin
      count_next_s = count_r - ONE_C;
    end else begin
      count_next_s = count_r;
    end
    if (state_r == RD_WAIT) begin
      rd_valid_next_s = 1'b1;
    end else if (consume_s) begin
      rd_valid_next_s = 1'b0;
    end else begin
      rd_valid_next_s = rd_valid_r;
    end
    level_next_s = count_next_s + {{ADDR_WIDTH{1'b0}}, rd_valid_next_s};
  end

  // Controller FSM with the output register it fills.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      rd_valid_r <= 1'b0;
      rd_data_r  <= {WIDTH{1'b0}};
    end else begin
      rd_valid_r <= rd_valid_next_s;
      case (state_r)
        IDLE: begin
          if (issue_rd_s) begin
            state_r <= RD_WAIT;
          end else begin
            state_r <= IDLE;
          end
        end
        RD_WAIT: begin
          rd_data_r <= ram_dout;
          state_r   <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Occupancy registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r <= ZERO_C;
      level_r <= ZERO_C;
    end else begin
      count_r <= count_next_s;
      level_r <= level_next_s;
    end
  end

`ifdef RAM_FIFO_CTRL_AFULL_EN
  localparam logic [ADDR_WIDTH:0] AF_C = (ADDR_WIDTH+1)'(AF_THRESH);
  logic almost_full_r;

  // Almost-full flag, computed from next-state level so it tracks level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      almost_full_r <= 1'b0;
    end else begin
      almost_full_r <= (level_next_s >= AF_C);
    end
  end

  assign almost_full = almost_full_r;
`endif

  ram_fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .inc (wr_fire_s),
    .ptr (wr_ptr_s)
  );

  ram_fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .inc (issue_rd_s),
    .ptr (rd_ptr_s)
  );

  assign wr_ready = wr_ready_s;
  assign ram_we   = wr_fire_s;
  assign ram_din  = wr_data;
  assign ram_addr = ram_addr_s;
  assign rd_valid = rd_valid_r;
  assign rd_data  = rd_data_r;
  assign level    = level_r;

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Testbench for ram_fifo_ctrl (WIDTH=8, ADDR_WIDTH=2) with a behavioural
// single-port RAM and a queue-based reference model of the FIFO.
module tb_ram_fifo_ctrl;

  localparam int WIDTH = 8;
  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             wr_valid = 1'b0;
  logic             wr_ready;
  logic [WIDTH-1:0] wr_data = 8'h00;
  logic             rd_valid;
  logic             rd_ready = 1'b0;
  logic [WIDTH-1:0] rd_data;
  logic             ram_we;
  logic [WIDTH-1:0] ram_din;
  logic [AW-1:0]    ram_addr;
  logic [WIDTH-1:0] ram_dout;
  logic [AW:0]      level;
`ifdef RAM_FIFO_CTRL_AFULL_EN
  logic             almost_full;
`endif

  always #5 clk = ~clk;

  ram_fifo_ctrl #(
    .WIDTH(WIDTH),
    .ADDR_WIDTH(AW)
`ifdef RAM_FIFO_CTRL_AFULL_EN
    , .AF_THRESH(3)
`endif
  ) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .ram_we(ram_we), .ram_din(ram_din), .ram_addr(ram_addr),
    .ram_dout(ram_dout), .level(level)
`ifdef RAM_FIFO_CTRL_AFULL_EN
    , .almost_full(almost_full)
`endif
  );

  // Single-port RAM with synchronous read.
  logic [WIDTH-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  int checks = 0;
  int errors = 0;

  // Reference model: words in RAM (queue), word in flight, output register.
  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] got_q[$];
  bit               out_valid, pending;
  logic [WIDTH-1:0] out_word, inflight;
  int               wr_total, rd_total, cyc, cons_cyc;
  bit               fired, consumed;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    out_valid = 1'b0;
    pending   = 1'b0;
    wr_total  = 0;
    rd_total  = 0;
  endtask

  // One clock: compare outputs mid-cycle, then advance the model at the edge.
  task automatic step();
    bit            p_issue, p_wr_ready;
    int            lvl;
    logic [AW-1:0] p_addr;
    logic [WIDTH-1:0] wd;
    @(negedge clk);
    p_issue    = !pending && !out_valid && (q.size() != 0);
    p_wr_ready = !pending && !p_issue && (q.size() != DEPTH);
    lvl        = q.size() + (out_valid ? 1 : 0);
    if (pending)      p_addr = AW'((rd_total - 1) % DEPTH);
    else if (p_issue) p_addr = AW'(rd_total % DEPTH);
    else              p_addr = AW'(wr_total % DEPTH);
    fired    = wr_valid && p_wr_ready;
    consumed = out_valid && rd_ready;
    wd       = wr_data;
    check("wr_ready", 32'(wr_ready), 32'(p_wr_ready));
    check("ram_we", 32'(ram_we), 32'(fired));
    check("ram_addr", 32'(ram_addr), 32'(p_addr));
    check("rd_valid", 32'(rd_valid), 32'(out_valid));
    check("level", 32'(level), 32'(lvl));
    if (out_valid) check("rd_data", 32'(rd_data), 32'(out_word));
    if (fired) check("ram_din", 32'(ram_din), 32'(wd));
`ifdef RAM_FIFO_CTRL_AFULL_EN
    check("almost_full", 32'(almost_full), 32'(lvl >= 3));
`endif
    if (consumed) begin
      got_q.push_back(rd_data);
      cons_cyc = cyc;
    end
    @(posedge clk);
    cyc++;
    if (pending) begin
      out_valid = 1'b1;
      out_word  = inflight;
      pending   = 1'b0;
    end else if (consumed) begin
      out_valid = 1'b0;
    end
    if (p_issue) begin
      inflight = q.pop_front();
      pending  = 1'b1;
      rd_total++;
    end
    if (fired) begin
      q.push_back(wd);
      wr_total++;
    end
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b0;
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] t2_words [6];
    logic [WIDTH-1:0] t4_words [20];
    int widx;
    int last;
    t2_words[0] = 8'hAA; t2_words[1] = 8'hBB; t2_words[2] = 8'hCC;
    t2_words[3] = 8'hDD; t2_words[4] = 8'hEE; t2_words[5] = 8'h11;
    cyc = 0;

    // Test 1: single write into an empty FIFO.
    do_reset();
    wr_valid = 1'b1; wr_data = 8'hAA;
    step();
    wr_valid = 1'b0;
    step();
    step();
    check("t1_rd_valid", 32'(rd_valid), 32'd1);
    check("t1_rd_data", 32'(rd_data), 32'hAA);
    check("t1_level", 32'(level), 32'd1);

    // Test 2: fill past capacity with the consumer stalled.
    do_reset();
    widx = 0;
    wr_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      wr_data = t2_words[(widx < 6) ? widx : 5];
      step();
      if (fired) widx++;
    end
    check("t2_level", 32'(level), 32'd5);
    check("t2_wr_ready", 32'(wr_ready), 32'd0);
    check("t2_rd_data", 32'(rd_data), 32'hAA);

    // Test 3: drain in order, read address wraps.
    wr_valid = 1'b0;
    got_q.delete();
    rd_ready = 1'b1;
    repeat (25) step();
    check("t3_count", 32'(got_q.size()), 32'd5);
    for (int i = 0; i < 5 && i < got_q.size(); i++) check("t3_order", 32'(got_q[i]), 32'(t2_words[i]));
    check("t3_rd_valid", 32'(rd_valid), 32'd0);
    check("t3_level", 32'(level), 32'd0);

    // Test 4: steady stream, 1 word per 3 cycles, no loss or reordering.
    do_reset();
    for (int i = 0; i < 20; i++) t4_words[i] = WIDTH'($urandom);
    got_q.delete();
    widx = 0; last = -1;
    rd_ready = 1'b1;
    for (int i = 0; i < 200 && got_q.size() < 20; i++) begin
      wr_valid = (widx < 20);
      wr_data  = t4_words[(widx < 20) ? widx : 19];
      step();
      if (fired) widx++;
      if (consumed) begin
        if (last >= 0) check("t4_interval", 32'(cons_cyc - last), 32'd3);
        last = cons_cyc;
      end
    end
    check("t4_count", 32'(got_q.size()), 32'd20);
    for (int i = 0; i < 20 && i < got_q.size(); i++) check("t4_order", 32'(got_q[i]), 32'(t4_words[i]));

    // Test 5: asynchronous reset while a read is in flight.
    do_reset();
    wr_valid = 1'b1; wr_data = 8'h5A;
    step();
    wr_valid = 1'b0;
    step(); step();
    wr_valid = 1'b1; wr_data = 8'h6B;
    step();
    wr_valid = 1'b0; rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    step();
    check("t5_in_rd_wait", 32'(pending), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("t5_rd_valid", 32'(rd_valid), 32'd0);
    check("t5_level", 32'(level), 32'd0);
    check("t5_ram_addr", 32'(ram_addr), 32'd0);
    check("t5_wr_ready", 32'(wr_ready), 32'd1);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    wr_valid = 1'b1; wr_data = 8'hC3;
    step();
    wr_valid = 1'b0;
    repeat (3) step();
    check("t5_rd_data", 32'(rd_data), 32'hC3);

    // Random traffic against the model, then drain.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      wr_valid = 1'($urandom_range(0, 1));
      rd_ready = 1'($urandom_range(0, 1));
      wr_data  = WIDTH'($urandom);
      step();
    end
    wr_valid = 1'b0; rd_ready = 1'b1;
    repeat (30) step();
    check("rand_drain_level", 32'(level), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
